// File: rtl/cmd_frame_decoder.sv
// rtl/cmd_frame_decoder.sv - gap-delimited command frame decoder driving host select, CPU reset and power
module cmd_frame_decoder #(
  parameter int          NCH          = 2,
  parameter int          SELW         = 4,
  parameter int          GAP_CYCLES   = 2000,
  parameter int          RESET_CYCLES = 50000,
  parameter logic [7:0]  HDR0         = 8'hEB,
  parameter logic [7:0]  HDR1         = 8'h90,
  parameter logic [7:0]  TAIL0        = 8'h09,
  parameter logic [7:0]  TAIL1        = 8'hD7,
  parameter logic [7:0]  TARGET       = 8'hAB,
  parameter int          FRAME_LEN    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [SELW-1:0]  host_sel,
  output logic             sel_strobe,
  output logic [NCH-1:0]   cpu_rst,
  output logic [NCH-1:0]   pwr_on,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic             rx_drop
);

  localparam int CW = $clog2(FRAME_LEN + 2);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, EXEC} state_t;

  state_t          state_q;
  logic [7:0]      frame_q [FRAME_LEN];
  logic [CW-1:0]   count_q;
  logic [GW-1:0]   gap_q;
  logic [RW-1:0]   rst_cnt_q [NCH];
  logic [SELW-1:0] host_sel_q;
  logic [NCH-1:0]  pwr_on_q;
  logic            sel_strobe_q, frame_ok_q, frame_err_q, rx_drop_q;
  logic [2:0]      err_code_q;

  logic [7:0]      sum_d;
  logic [3:0]      action_d, ch_d;
  logic [SELW-1:0] ch_sel_d;
  logic            op_ok_d, ch_pwr_d;
  logic [2:0]      err_d;

  always_comb begin
    sum_d = '0;
    for (int i = 2; i <= FRAME_LEN - 3; i++) sum_d = sum_d + frame_q[i];
    action_d = frame_q[4][7:4];
    ch_d     = frame_q[4][3:0];
    ch_sel_d = SELW'(ch_d);
    op_ok_d  = (action_d >= 4'd1) && (action_d <= 4'd5) && (int'(ch_d) < NCH);
    ch_pwr_d = 1'b0;
    for (int i = 0; i < NCH; i++) if (int'(ch_d) == i) ch_pwr_d = pwr_on_q[i];
    // First failing cause wins; ordering matters when several checks fail at once.
    if (count_q < CW'(FRAME_LEN))                                 err_d = 3'd1;
    else if (count_q > CW'(FRAME_LEN))                            err_d = 3'd2;
    else if (frame_q[0] != HDR0 || frame_q[1] != HDR1)            err_d = 3'd3;
    else if (frame_q[FRAME_LEN-2] != TAIL0 ||
             frame_q[FRAME_LEN-1] != TAIL1)                       err_d = 3'd4;
    else if (sum_d != 8'd0)                                       err_d = 3'd5;
    else if (frame_q[3] != TARGET)                                err_d = 3'd6;
    else if (!op_ok_d)                                            err_d = 3'd7;
    else                                                          err_d = 3'd0;
    cpu_rst = '0;
    for (int i = 0; i < NCH; i++) cpu_rst[i] = (rst_cnt_q[i] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      gap_q        <= '0;
      for (int i = 0; i < FRAME_LEN; i++) frame_q[i] <= '0;
      for (int i = 0; i < NCH; i++) rst_cnt_q[i] <= '0;
      host_sel_q   <= '0;
      pwr_on_q     <= '1;
      sel_strobe_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_drop_q    <= 1'b0;
      err_code_q   <= '0;
    end else begin
      sel_strobe_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_drop_q    <= 1'b0;
      for (int i = 0; i < NCH; i++)
        if (rst_cnt_q[i] != '0) rst_cnt_q[i] <= rst_cnt_q[i] - RW'(1);
      case (state_q)
        IDLE: if (rx_valid) begin
          frame_q[0] <= rx_data;
          count_q    <= CW'(1);
          gap_q      <= '0;
          state_q    <= COLLECT;
        end
        COLLECT: begin
          if (rx_valid) begin
            for (int i = 0; i < FRAME_LEN; i++)
              if (int'(count_q) == i) frame_q[i] <= rx_data;
            if (count_q <= CW'(FRAME_LEN)) count_q <= count_q + CW'(1);
            gap_q <= '0;
          end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= CHECK;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        CHECK: begin
          rx_drop_q <= rx_valid;
          if (err_d != 3'd0) begin
            err_code_q  <= err_d;
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rx_drop_q  <= rx_valid;
          frame_ok_q <= 1'b1;
          state_q    <= IDLE;
          case (action_d)
            4'h1: begin
              host_sel_q   <= ch_sel_d;
              sel_strobe_q <= 1'b1;
            end
            4'h2: if (ch_sel_d != host_sel_q)
              for (int i = 0; i < NCH; i++)
                if (int'(ch_d) == i) rst_cnt_q[i] <= RW'(RESET_CYCLES);
            4'h3: begin
              for (int i = 0; i < NCH; i++) rst_cnt_q[i] <= RW'(RESET_CYCLES);
              host_sel_q   <= ch_sel_d;
              sel_strobe_q <= 1'b1;
            end
            4'h4: begin
              for (int i = 0; i < NCH; i++)
                if (int'(ch_d) == i) pwr_on_q[i] <= 1'b1;
              if (!ch_pwr_d) begin
                host_sel_q   <= ch_sel_d;
                sel_strobe_q <= 1'b1;
              end
            end
            4'h5: if (ch_sel_d != host_sel_q)
              for (int i = 0; i < NCH; i++)
                if (int'(ch_d) == i) pwr_on_q[i] <= 1'b0;
            default: ;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_sel   = host_sel_q;
  assign sel_strobe = sel_strobe_q;
  assign pwr_on     = pwr_on_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign rx_drop    = rx_drop_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// tb/tb_cmd_frame_decoder.sv - directed bench for cmd_frame_decoder
module tb_cmd_frame_decoder;

  localparam int G  = 8;
  localparam int RC = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [3:0] host_sel;
  logic       sel_strobe;
  logic [1:0] cpu_rst;
  logic [1:0] pwr_on;
  logic       frame_ok, frame_err, rx_drop;
  logic [2:0] err_code;

  cmd_frame_decoder #(.NCH(2), .SELW(4), .GAP_CYCLES(G), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .host_sel(host_sel), .sel_strobe(sel_strobe), .cpu_rst(cpu_rst), .pwr_on(pwr_on),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_sel = 0, n_ok = 0, n_ferr = 0, n_drop = 0, n_rst0 = 0;
  int b_sel, b_ok, b_ferr, b_drop, b_rst0;
  logic [7:0] q [$];

  always @(negedge clk) begin
    if (sel_strobe) n_sel++;
    if (frame_ok)   n_ok++;
    if (frame_err)  n_ferr++;
    if (rx_drop)    n_drop++;
    if (cpu_rst[0]) n_rst0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_sel = n_sel; b_ok = n_ok; b_ferr = n_ferr; b_drop = n_drop; b_rst0 = n_rst0;
  endtask

  task automatic send_q();
    foreach (q[i]) begin
      rx_data = q[i]; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (G + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_sel", 32'(host_sel), 0);
    chk("rst_pwr_on", 32'(pwr_on), 32'h3);
    chk("rst_cpu_rst", 32'(cpu_rst), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_pulses", {28'd0, sel_strobe, frame_ok, frame_err, rx_drop}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    snap();
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h11, 8'h44, 8'h09, 8'hD7};
    send_q(); settle();
    chk("sel_host_sel", 32'(host_sel), 1);
    chk("sel_strobe_cnt", n_sel - b_sel, 1);
    chk("sel_ok_cnt", n_ok - b_ok, 1);
    chk("sel_err_cnt", n_ferr - b_ferr, 0);

    snap();
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h20, 8'h35, 8'h09, 8'hD7};
    send_q(); settle();
    repeat (RC + 4) @(posedge clk);
    #1;
    chk("rst0_width", n_rst0 - b_rst0, RC);
    chk("rst0_ok_cnt", n_ok - b_ok, 1);
    chk("rst0_done", 32'(cpu_rst), 0);

    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h10, 8'h45, 8'h09, 8'hD7};
    send_q(); settle();
    chk("sel0_host_sel", 32'(host_sel), 0);
    snap();
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h20, 8'h35, 8'h09, 8'hD7};
    send_q(); settle();
    repeat (4) @(posedge clk);
    #1;
    chk("rst_self_ok_cnt", n_ok - b_ok, 1);
    chk("rst_self_width", n_rst0 - b_rst0, 0);

    snap();
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h11, 8'h44, 8'h09};
    send_q(); settle();
    chk("short_code", 32'(err_code), 1);
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h11, 8'h44, 8'h09, 8'hD7, 8'h00};
    send_q(); settle();
    chk("long_code", 32'(err_code), 2);
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h11, 8'h45, 8'h09, 8'hD7};
    send_q(); settle();
    chk("csum_code", 32'(err_code), 5);
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h13, 8'h42, 8'h09, 8'hD7};
    send_q(); settle();
    chk("badch_code", 32'(err_code), 7);
    chk("err_frame_err_cnt", n_ferr - b_ferr, 4);
    chk("err_ok_cnt", n_ok - b_ok, 0);
    chk("err_sel_cnt", n_sel - b_sel, 0);
    chk("err_host_sel", 32'(host_sel), 0);
    chk("err_pwr_on", 32'(pwr_on), 32'h3);

    snap();
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB};
    send_q();
    repeat (G - 1) @(posedge clk);
    #1;
    q = '{8'h11, 8'h44, 8'h09, 8'hD7};
    send_q(); settle();
    chk("gap_edge_host_sel", 32'(host_sel), 1);
    chk("gap_edge_ok_cnt", n_ok - b_ok, 1);
    chk("gap_edge_err_cnt", n_ferr - b_ferr, 0);

    snap();
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h10, 8'h45, 8'h09, 8'hD7};
    send_q();
    repeat (G) @(posedge clk);
    #1;
    rx_data = 8'hEB; rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    settle();
    chk("drop_cnt", n_drop - b_drop, 2);
    chk("drop_host_sel", 32'(host_sel), 0);
    chk("drop_ok_cnt", n_ok - b_ok, 1);
    chk("drop_err_cnt", n_ferr - b_ferr, 0);

    snap();
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h51, 8'h04, 8'h09, 8'hD7};
    send_q(); settle();
    chk("pwr_off_pwr_on", 32'(pwr_on), 32'h1);
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h41, 8'h14, 8'h09, 8'hD7};
    send_q(); settle();
    chk("pwr_on_pwr_on", 32'(pwr_on), 32'h3);
    chk("pwr_on_host_sel", 32'(host_sel), 1);
    chk("pwr_on_sel_cnt", n_sel - b_sel, 1);

    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h50, 8'h05, 8'h09, 8'hD7};
    send_q(); settle();
    chk("pwr_off0_pwr_on", 32'(pwr_on), 32'h2);
    q = '{8'hEB, 8'h90, 8'h00, 8'hAB, 8'h31, 8'h24, 8'h09, 8'hD7};
    send_q(); settle();
    repeat (8) @(posedge clk);
    #1;
    chk("rstall_cpu_rst", 32'(cpu_rst), 32'h3);
    chk("rstall_host_sel", 32'(host_sel), 1);
    rst_n = 1'b0;
    #1;
    chk("async_cpu_rst", 32'(cpu_rst), 0);
    chk("async_host_sel", 32'(host_sel), 0);
    chk("async_pwr_on", 32'(pwr_on), 32'h3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
